// File: rtl/perf_pkg.sv
// Shared types for the performance-counter bank: FSM state encoding and
// the mapping from event channel to readout select value.
package perf_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } perf_state_e;

   localparam int RD_SEL_CYCLE = 0;

   // Event channel k sits right after the cycle counter in the readout map.
   function automatic int evt_rd_sel(input int k);
      return k + 1;
   endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a sticky flag that records any increment
// requested while the counter was already at all-ones.
module perf_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_o <= '0;
         sat_o <= 1'b0;
      end else if (clr_i) begin
         cnt_o <= '0;
         sat_o <= 1'b0;
      end else if (inc_i) begin
         if (cnt_o == CNT_MAX) begin
            sat_o <= 1'b1;
         end else begin
            cnt_o <= cnt_o + 1'b1;
         end
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// Performance-monitor bank: run-cycle counter plus NUM_EVT event counters,
// a cycle-limit FSM and an atomic snapshot register file for readout.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_EVT = 4,
   parameter int CNT_W   = 32,
   parameter int SEL_W   = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic [NUM_EVT-1:0] evt_i,
   input  logic               clear_i,
   input  logic               snap_i,
   input  logic [CNT_W-1:0]   limit_i,
   input  logic [SEL_W-1:0]   rd_sel_i,
   output logic [CNT_W-1:0]   rd_data_o,
   output logic [CNT_W-1:0]   cycle_o,
   output logic [1:0]         state_o,
   output logic               done_o,
   output logic               snap_valid_o,
   output logic [NUM_EVT:0]   ovf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   perf_state_e      state_q, state_d;
   logic             count_en;
   logic             limit_hit;
   logic [NUM_EVT:0] inc_vec;
   logic [CNT_W-1:0] cycle_next;
   logic [CNT_W-1:0] live     [NUM_EVT+1];
   logic [CNT_W-1:0] shadow_q [NUM_EVT+1];
   logic             snap_valid_q;

   assign count_en = (state_q == RUN);
   assign inc_vec  = {evt_i, 1'b1} & {(NUM_EVT+1){count_en}};

   // Slot 0 is the cycle counter, slot k+1 is event channel k.
   for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
      perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk_i  (clk_i),
         .rst_n_i(rst_n_i),
         .clr_i  (clear_i),
         .inc_i  (inc_vec[g]),
         .cnt_o  (live[g]),
         .sat_o  (ovf_o[g])
      );
   end

   // A saturated cycle counter stays at all-ones, so it only matches an all-ones limit.
   assign cycle_next = (live[0] == CNT_MAX) ? CNT_MAX : live[0] + 1'b1;
   assign limit_hit  = (limit_i != '0) && (cycle_next == limit_i);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN: begin
            if (limit_hit) begin
               state_d = DONE;
            end else if (!start_i) begin
               state_d = PAUSE;
            end
         end
         PAUSE:   if (start_i) state_d = RUN;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = IDLE;
      end
   end

   // Shadows take the registered (pre-update) values and survive clear_i.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int k = 0; k <= NUM_EVT; k++) begin
            shadow_q[k] <= '0;
         end
         snap_valid_q <= 1'b0;
      end else begin
         if (snap_i) begin
            for (int k = 0; k <= NUM_EVT; k++) begin
               shadow_q[k] <= live[k];
            end
         end
         snap_valid_q <= snap_i;
      end
   end

   always_comb begin
      rd_data_o = '0;
      if (rd_sel_i == SEL_W'(RD_SEL_CYCLE)) begin
         rd_data_o = shadow_q[0];
      end
      for (int k = 0; k < NUM_EVT; k++) begin
         if (rd_sel_i == SEL_W'(evt_rd_sel(k))) begin
            rd_data_o = shadow_q[k+1];
         end
      end
   end

   assign cycle_o      = live[0];
   assign state_o      = state_q;
   assign done_o       = (state_q == DONE);
   assign snap_valid_o = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed and randomized bench for perf_counter_bank, checked against a
// reference model built from unbounded increment tallies clamped at readout.
module tb_perf_counter_bank;

   localparam int     NUM_EVT = 4;
   localparam int     CNT_W   = 32;
   localparam int     SEL_W   = 4;
   localparam int     SMALL_W = 4;
   localparam longint MAXV    = 64'h0000_0000_FFFF_FFFF;
   localparam int     M_IDLE  = 0;
   localparam int     M_RUN   = 1;
   localparam int     M_PAUSE = 2;
   localparam int     M_DONE  = 3;

   logic               clk_i = 1'b0;
   logic               rst_n_i;
   logic               start_i;
   logic [NUM_EVT-1:0] evt_i;
   logic               clear_i;
   logic               snap_i;
   logic [CNT_W-1:0]   limit_i;
   logic [SEL_W-1:0]   rd_sel_i;
   logic [CNT_W-1:0]   rd_data_o;
   logic [CNT_W-1:0]   cycle_o;
   logic [1:0]         state_o;
   logic               done_o;
   logic               snap_valid_o;
   logic [NUM_EVT:0]   ovf_o;

   logic               s_start;
   logic [NUM_EVT-1:0] s_evt;
   logic               s_clear;
   logic               s_snap;
   logic [SMALL_W-1:0] s_limit;
   logic [SEL_W-1:0]   s_rd_sel;
   logic [SMALL_W-1:0] s_rd_data;
   logic [SMALL_W-1:0] s_cycle;
   logic [1:0]         s_state;
   logic               s_done;
   logic               s_snap_valid;
   logic [NUM_EVT:0]   s_ovf;

   int     errors = 0;
   int     checks = 0;
   longint att [NUM_EVT+1];
   longint msh [NUM_EVT+1];
   int     mstate;
   bit     mvalid;

   perf_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .evt_i(evt_i),
      .clear_i(clear_i), .snap_i(snap_i), .limit_i(limit_i), .rd_sel_i(rd_sel_i),
      .rd_data_o(rd_data_o), .cycle_o(cycle_o), .state_o(state_o), .done_o(done_o),
      .snap_valid_o(snap_valid_o), .ovf_o(ovf_o)
   );

   perf_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(SMALL_W), .SEL_W(SEL_W)) dut_small (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(s_start), .evt_i(s_evt),
      .clear_i(s_clear), .snap_i(s_snap), .limit_i(s_limit), .rd_sel_i(s_rd_sel),
      .rd_data_o(s_rd_data), .cycle_o(s_cycle), .state_o(s_state), .done_o(s_done),
      .snap_valid_o(s_snap_valid), .ovf_o(s_ovf)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint mcnt(input int k);
      return (att[k] > MAXV) ? MAXV : att[k];
   endfunction

   function automatic logic [NUM_EVT:0] movf();
      logic [NUM_EVT:0] v;
      for (int k = 0; k <= NUM_EVT; k++) v[k] = (att[k] > MAXV);
      return v;
   endfunction

   function automatic longint mrd(input int sel);
      return (sel <= NUM_EVT) ? msh[sel] : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k <= NUM_EVT; k++) begin
         att[k] = 0;
         msh[k] = 0;
      end
      mstate = M_IDLE;
      mvalid = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs stable at that edge.
   task automatic model_edge();
      longint nxt;
      if (snap_i) begin
         for (int k = 0; k <= NUM_EVT; k++) msh[k] = mcnt(k);
      end
      mvalid = snap_i;
      if (clear_i) begin
         for (int k = 0; k <= NUM_EVT; k++) att[k] = 0;
         mstate = M_IDLE;
      end else begin
         case (mstate)
            M_IDLE, M_PAUSE: if (start_i) mstate = M_RUN;
            M_RUN: begin
               nxt = (att[0] + 1 > MAXV) ? MAXV : att[0] + 1;
               if (limit_i != 0 && nxt == longint'(limit_i)) mstate = M_DONE;
               else if (!start_i) mstate = M_PAUSE;
               att[0]++;
               for (int k = 0; k < NUM_EVT; k++) if (evt_i[k]) att[k+1]++;
            end
            default: ;
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      if (!rst_n_i) model_reset();
      else model_edge();
      #1;
      check_output("state", 64'(state_o), 64'(mstate));
      check_output("cycle", 64'(cycle_o), 64'(mcnt(0)));
      check_output("done", 64'(done_o), 64'(mstate == M_DONE));
      check_output("snap_valid", 64'(snap_valid_o), 64'(mvalid));
      check_output("ovf", 64'(ovf_o), 64'(movf()));
      check_output("rd_data", 64'(rd_data_o), 64'(mrd(int'(rd_sel_i))));
   endtask

   task automatic apply_stimulus(input logic start, input logic [NUM_EVT-1:0] evt,
                                 input logic clr, input logic snap);
      start_i = start;
      evt_i   = evt;
      clear_i = clr;
      snap_i  = snap;
   endtask

   task automatic read_check(input int sel, input string tag, input longint exp);
      rd_sel_i = SEL_W'(sel);
      #1;
      check_output(tag, 64'(rd_data_o), 64'(exp));
   endtask

   initial begin
      logic ev;
      bit   hit;
      rst_n_i = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      limit_i = '0;
      rd_sel_i = '0;
      s_start = 1'b0; s_evt = '0; s_clear = 1'b0; s_snap = 1'b0;
      s_limit = '0; s_rd_sel = '0;
      model_reset();

      // Reset and idle
      step(); step();
      rst_n_i = 1'b1;
      for (int i = 0; i < 5; i++) step();
      for (int s = 0; s <= NUM_EVT; s++) read_check(s, "idle_rd", 0);

      // Limited run to 100 with evt[0] toggling
      limit_i = 100;
      start_i = 1'b1;
      ev = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         evt_i = {3'b000, ev};
         step();
         ev = ~ev;
         if (done_o) hit = 1'b1;
      end
      check_output("limit_reached", 64'(hit), 64'd1);
      check_output("done_at_100", 64'(cycle_o), 64'd100);
      evt_i = '0;
      snap_i = 1'b1;
      step();
      snap_i = 1'b0;
      step();
      read_check(0, "limit_snap_cycle", 100);
      read_check(1, "limit_snap_evt0", 50);
      for (int i = 0; i < 20; i++) step();
      check_output("frozen_cycle", 64'(cycle_o), 64'd100);
      check_output("frozen_done", 64'(done_o), 64'd1);

      // Pause with all events active
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      step();
      limit_i = '0;
      apply_stimulus(1'b1, 4'b1111, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step();
      start_i = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check_output("pause_state", 64'(state_o), 64'd2);
      start_i = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check_output("pause_cycle", 64'(cycle_o), 64'd15);
      apply_stimulus(1'b0, 4'b1111, 1'b0, 1'b1);
      step();
      snap_i = 1'b0;
      for (int s = 0; s <= NUM_EVT; s++) read_check(s, "pause_snap", 15);

      // Saturation on the narrow instance
      s_start = 1'b1;
      s_evt = 4'b0010;
      for (int i = 0; i < 21; i++) step();
      check_output("sat_cycle", 64'(s_cycle), 64'd15);
      check_output("sat_ovf", 64'(s_ovf), 64'b00101);
      s_snap = 1'b1;
      step();
      s_snap = 1'b0;
      s_rd_sel = 2;
      #1;
      check_output("sat_evt1", 64'(s_rd_data), 64'd15);
      s_rd_sel = 0;
      #1;
      check_output("sat_rd_cycle", 64'(s_rd_data), 64'd15);
      s_start = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check_output("sat_ovf_sticky", 64'(s_ovf), 64'b00101);
      s_clear = 1'b1;
      step();
      s_clear = 1'b0;
      check_output("sat_clr_cycle", 64'(s_cycle), 64'd0);
      check_output("sat_clr_ovf", 64'(s_ovf), 64'd0);
      check_output("sat_clr_state", 64'(s_state), 64'd0);

      // Snap and clear in the same cycle
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      step();
      apply_stimulus(1'b1, 4'b0100, 1'b0, 1'b0);
      for (int i = 0; i < 31; i++) step();
      check_output("coll_pre_cycle", 64'(cycle_o), 64'd30);
      apply_stimulus(1'b0, '0, 1'b1, 1'b1);
      step();
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("coll_live", 64'(cycle_o), 64'd0);
      check_output("coll_pulse", 64'(snap_valid_o), 64'd1);
      read_check(3, "coll_evt2", 30);
      read_check(0, "coll_cycle", 30);
      step();
      check_output("coll_pulse_end", 64'(snap_valid_o), 64'd0);

      // Asynchronous reset between edges after 42 run cycles
      apply_stimulus(1'b1, 4'b1001, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 42; i++) begin
         snap_i = (i == 20);
         step();
      end
      snap_i = 1'b0;
      rd_sel_i = 0;
      #2;
      rst_n_i = 1'b0;
      #1;
      model_reset();
      check_output("arst_state", 64'(state_o), 64'd0);
      check_output("arst_cycle", 64'(cycle_o), 64'd0);
      check_output("arst_ovf", 64'(ovf_o), 64'd0);
      check_output("arst_done", 64'(done_o), 64'd0);
      check_output("arst_shadow", 64'(rd_data_o), 64'd0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      step(); step();
      rst_n_i = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         start_i  = ($urandom_range(0, 9) != 0);
         evt_i    = NUM_EVT'($urandom);
         clear_i  = ($urandom_range(0, 49) == 0);
         snap_i   = ($urandom_range(0, 9) == 0);
         rd_sel_i = SEL_W'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            limit_i = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 120));
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
